// File: rtl/cdb_arbiter_pkg.sv
// Shared backend types for the CDB arbiter slice: execution-unit count,
// ROB/PRF index widths and the broadcast packet layout.
package backend_types;

    localparam int unsigned NUM_EU         = 4;
    localparam int unsigned ROB_ADDR_WIDTH = 5;
    localparam int unsigned PRF_ADDR_WIDTH = 6;
    localparam int unsigned XLEN           = 32;
    localparam int unsigned EU_IDX_W       = $clog2(NUM_EU);

    typedef enum logic [EU_IDX_W-1:0] {
        EU_INT = 2'd0,
        EU_MUD = 2'd1,
        EU_BRA = 2'd2,
        EU_MEM = 2'd3
    } eu_id_e;

    typedef struct packed {
        logic [ROB_ADDR_WIDTH-1:0] rob_id;
        logic [PRF_ADDR_WIDTH-1:0] pd;
        logic [XLEN-1:0]           result;
        logic [EU_IDX_W-1:0]       src;
    } cdb_pkt_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Requester handshake, flush and CDB broadcast bundle; the arbiter takes the
// slave side, the execution units / bench take the master side.
interface cdb_arbiter_if
    import backend_types::*;
#(
    parameter int unsigned NUM_REQ    = NUM_EU,
    parameter int unsigned DATA_WIDTH = 32
) ();

    localparam int unsigned SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]                     req_valid;
    logic [NUM_REQ-1:0]                     req_ready;
    logic [NUM_REQ-1:0][ROB_ADDR_WIDTH-1:0] req_rob_id;
    logic [NUM_REQ-1:0][PRF_ADDR_WIDTH-1:0] req_pd;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0]     req_result;
    logic                                   flush;

    logic                      cdb_valid;
    logic [ROB_ADDR_WIDTH-1:0] cdb_rob_id;
    logic [PRF_ADDR_WIDTH-1:0] cdb_pd;
    logic [DATA_WIDTH-1:0]     cdb_result;
    logic [SRC_W-1:0]          cdb_src;

    modport master (
        output req_valid, req_rob_id, req_pd, req_result, flush,
        input  req_ready, cdb_valid, cdb_rob_id, cdb_pd, cdb_result, cdb_src
    );

    modport slave (
        input  req_valid, req_rob_id, req_pd, req_result, flush,
        output req_ready, cdb_valid, cdb_rob_id, cdb_pd, cdb_result, cdb_src
    );

endinterface

// File: rtl/cdb_arbiter_rr_arbiter.sv
// Round-robin pick: first set request at or after ptr_i, wrapping; returns a
// one-hot grant, the winner index and whether anything was granted.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    int unsigned      pos;
    logic [IDX_W-1:0] sel;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        pos     = 0;
        sel     = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            pos = {{(32-IDX_W){1'b0}}, ptr_i} + k;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            sel = IDX_W'(pos);
            if (!any_o && req_i[sel]) begin
                any_o        = 1'b1;
                idx_o        = sel;
                grant_o[sel] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin selection of one finished result per
// cycle onto registered cdb_* outputs. Optional macro CDB_ARB_SKID_EN adds a
// one-entry skid buffer per requester (registered ready, 2-cycle latency).
module cdb_arbiter
    import backend_types::*;
#(
    parameter int unsigned NUM_REQ    = NUM_EU,
    parameter int unsigned DATA_WIDTH = 32
) (
    input logic          clk,
    input logic          rst,
    cdb_arbiter_if.slave bus
);

    localparam int unsigned SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]        cand;
    logic [NUM_REQ-1:0]        grant;
    logic [SRC_W-1:0]          win_idx;
    logic                      win_any;
    logic [ROB_ADDR_WIDTH-1:0] win_rob_id;
    logic [PRF_ADDR_WIDTH-1:0] win_pd;
    logic [DATA_WIDTH-1:0]     win_result;

    logic [SRC_W-1:0]          rr_ptr_q, rr_ptr_d;
    logic                      cdb_valid_q, cdb_valid_d;
    logic [ROB_ADDR_WIDTH-1:0] cdb_rob_id_q, cdb_rob_id_d;
    logic [PRF_ADDR_WIDTH-1:0] cdb_pd_q, cdb_pd_d;
    logic [DATA_WIDTH-1:0]     cdb_result_q, cdb_result_d;
    logic [SRC_W-1:0]          cdb_src_q, cdb_src_d;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (SRC_W)
    ) u_rr_arbiter (
        .req_i   (cand),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant),
        .idx_o   (win_idx),
        .any_o   (win_any)
    );

`ifdef CDB_ARB_SKID_EN
    logic [NUM_REQ-1:0]                     full_q, full_d;
    logic [NUM_REQ-1:0]                     accept;
    logic [NUM_REQ-1:0][ROB_ADDR_WIDTH-1:0] skid_rob_id_q, skid_rob_id_d;
    logic [NUM_REQ-1:0][PRF_ADDR_WIDTH-1:0] skid_pd_q, skid_pd_d;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0]     skid_result_q, skid_result_d;

    // Entries compete for the bus; a slot granted this cycle reopens next cycle.
    always_comb begin
        cand          = full_q & {NUM_REQ{~bus.flush}};
        bus.req_ready = ~full_q & {NUM_REQ{~(rst | bus.flush)}};
        accept        = bus.req_valid & bus.req_ready;
        full_d        = (full_q & ~grant) | accept;
        skid_rob_id_d = skid_rob_id_q;
        skid_pd_d     = skid_pd_q;
        skid_result_d = skid_result_q;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (accept[i]) begin
                skid_rob_id_d[i] = bus.req_rob_id[i];
                skid_pd_d[i]     = bus.req_pd[i];
                skid_result_d[i] = bus.req_result[i];
            end
        end
        if (bus.flush) begin
            full_d = '0;
        end
        win_rob_id = skid_rob_id_q[win_idx];
        win_pd     = skid_pd_q[win_idx];
        win_result = skid_result_q[win_idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q        <= '0;
            skid_rob_id_q <= '0;
            skid_pd_q     <= '0;
            skid_result_q <= '0;
        end else begin
            full_q        <= full_d;
            skid_rob_id_q <= skid_rob_id_d;
            skid_pd_q     <= skid_pd_d;
            skid_result_q <= skid_result_d;
        end
    end
`else
    // Masking candidates during reset/flush keeps every ready low in those cycles.
    always_comb begin
        cand          = bus.req_valid & {NUM_REQ{~(rst | bus.flush)}};
        bus.req_ready = grant;
        win_rob_id    = bus.req_rob_id[win_idx];
        win_pd        = bus.req_pd[win_idx];
        win_result    = bus.req_result[win_idx];
    end
`endif

    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        cdb_valid_d  = win_any;
        cdb_rob_id_d = cdb_rob_id_q;
        cdb_pd_d     = cdb_pd_q;
        cdb_result_d = cdb_result_q;
        cdb_src_d    = cdb_src_q;
        if (win_any) begin
            cdb_rob_id_d = win_rob_id;
            cdb_pd_d     = win_pd;
            cdb_result_d = win_result;
            cdb_src_d    = win_idx;
            rr_ptr_d     = (win_idx == SRC_W'(NUM_REQ - 1)) ? '0 : win_idx + SRC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q     <= '0;
            cdb_valid_q  <= 1'b0;
            cdb_rob_id_q <= '0;
            cdb_pd_q     <= '0;
            cdb_result_q <= '0;
            cdb_src_q    <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            cdb_valid_q  <= cdb_valid_d;
            cdb_rob_id_q <= cdb_rob_id_d;
            cdb_pd_q     <= cdb_pd_d;
            cdb_result_q <= cdb_result_d;
            cdb_src_q    <= cdb_src_d;
        end
    end

    assign bus.cdb_valid  = cdb_valid_q;
    assign bus.cdb_rob_id = cdb_rob_id_q;
    assign bus.cdb_pd     = cdb_pd_q;
    assign bus.cdb_result = cdb_result_q;
    assign bus.cdb_src    = cdb_src_q;

endmodule
